// File: rtl/nn_opm_pkg.sv
// nn_opm shared package: bus widths, output-layer geometry and
// OPM FSM state encodings.
package nn_opm_pkg;

  localparam int D_LEN     = 16;
  localparam int DA_AWIDTH = 8;
  localparam int OFS_WIDTH = 8;
  localparam int O_NUM     = 4;
  localparam int O_BASE    = 0;

  localparam logic [2:0] OPM_IDLE  = 3'd0;
  localparam logic [2:0] OPM_REQ   = 3'd1;
  localparam logic [2:0] OPM_READ  = 3'd2;
  localparam logic [2:0] OPM_DRAIN = 3'd3;
  localparam logic [2:0] OPM_DONE  = 3'd4;

endpackage

// File: rtl/nn_opm.sv
// nn_opm: sweeps O_NUM result words over the ROUTER_BUS opm port after
// nn_finish, thresholds each signed word to one bit, packs into o_out.
// Ports: clk, rst_n (sync, active low), nn_finish, opm_request/opm_enable
// handshake, opm_finish, opm_base/opm_offset/opm_dout, o_out, o_valid, busy.
module nn_opm
  import nn_opm_pkg::*;
#(
  parameter int D_LEN_P     = D_LEN,
  parameter int DA_AWIDTH_P = DA_AWIDTH,
  parameter int OFS_WIDTH_P = OFS_WIDTH,
  parameter int O_NUM_P     = O_NUM,
  parameter int O_BASE_P    = O_BASE,
  parameter logic signed [D_LEN_P-1:0] THRESH = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   nn_finish,
  output logic                   opm_request,
  input  logic                   opm_enable,
  output logic                   opm_finish,
  output logic [DA_AWIDTH_P-1:0] opm_base,
  output logic [OFS_WIDTH_P-1:0] opm_offset,
  input  logic [D_LEN_P-1:0]     opm_dout,
  output logic [O_NUM_P-1:0]     o_out,
  output logic                   o_valid,
  output logic                   busy
);

  localparam logic [OFS_WIDTH_P-1:0] LAST =
    OFS_WIDTH_P'(O_NUM_P - 1);

  logic [2:0]             state;
  logic [OFS_WIDTH_P-1:0] offset;
  logic                   pend;
  logic [OFS_WIDTH_P-1:0] pend_idx;
  logic [O_NUM_P-1:0]     cap;
  logic [O_NUM_P-1:0]     cap_nxt;
  logic                   hit;

  assign hit = $signed(opm_dout) > THRESH;

  // Data returns one cycle after its offset; pend_idx remembers
  // which slot that returning word belongs to.
  always_comb begin
    cap_nxt = cap;
    for (int i = 0; i < O_NUM_P; i++) begin
      if (pend && pend_idx == OFS_WIDTH_P'(i))
        cap_nxt[i] = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OPM_IDLE;
      offset   <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      cap      <= '0;
      o_out    <= '0;
    end else begin
      pend     <= (state == OPM_READ) && opm_enable;
      pend_idx <= offset;
      unique case (state)
        OPM_IDLE: begin
          if (nn_finish) begin
            state  <= OPM_REQ;
            offset <= '0;
            cap    <= '0;
          end
        end
        OPM_REQ: begin
          if (opm_enable)
            state <= OPM_READ;
        end
        OPM_READ: begin
          cap <= cap_nxt;
          if (opm_enable) begin
            if (offset == LAST)
              state <= OPM_DRAIN;
            else
              offset <= offset + 1'b1;
          end
        end
        OPM_DRAIN: begin
          cap   <= cap_nxt;
          o_out <= cap_nxt;
          state <= OPM_DONE;
        end
        OPM_DONE: begin
          offset <= '0;
          state  <= OPM_IDLE;
        end
        default: state <= OPM_IDLE;
      endcase
    end
  end

  assign opm_request = (state == OPM_REQ) ||
                       (state == OPM_READ) ||
                       (state == OPM_DRAIN);
  assign opm_finish  = (state == OPM_DONE);
  assign o_valid     = (state == OPM_DONE);
  assign busy        = (state != OPM_IDLE);
  assign opm_offset  = offset;
  assign opm_base    = DA_AWIDTH_P'(O_BASE_P);

endmodule
